// File: rtl/gx4000_pkg.sv
// Shared types for the GX4000 ASIC RAM arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gx4000_pkg;

    localparam int ASIC_RAM_AW = 14;

    // Requester ID carried alongside each in-flight RAM access
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_DMA  = 2'd2,
        REQ_CPU  = 2'd3
    } req_id_t;

endpackage

// File: rtl/gx4000_tag_pipe.sv
// Delay line of requester IDs that follows reads through the RAM so returns can be steered.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, cleared to REQ_NONE on reset.
module gx4000_tag_pipe
    import gx4000_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_sys,
    input  logic    reset_n,
    input  req_id_t tag_in,
    output req_id_t tag_out
);

    req_id_t stage_q [DEPTH];
    req_id_t stage_d [DEPTH];

    // Shift one stage per cycle; new tag enters at stage 0
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight tag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= REQ_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/gx4000_asic_ram_arb.sv
// Shares the single-port ASIC RAM between video, DMA and CPU (video > DMA > CPU, CPU promoted when starved).
// Latency: gnt and ram strobe one cycle after req is seen; read rvalid RAM_LAT+1 cycles after the strobe.
// Backpressure: requesters hold req until their one-cycle gnt; the granted requester is masked during its gnt cycle.
module gx4000_asic_ram_arb
    import gx4000_pkg::*;
#(
    parameter int ADDR_W     = ASIC_RAM_AW,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic [7:0]        rdata,
    output logic              vid_rvalid,
    output logic              dma_rvalid,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_q,
    output logic              cpu_starved
);

    localparam int                WAIT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

    logic              vid_gnt_q, vid_gnt_d;
    logic              dma_gnt_q, dma_gnt_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_din_q, ram_din_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              vid_rvalid_q, vid_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;

    logic    vid_elig, dma_elig, cpu_elig, cpu_promote;
    req_id_t winner;
    req_id_t issue_tag;
    req_id_t ret_tag;

    // Priority pick; a requester in its gnt cycle is still holding the old request, so it sits out
    always_comb begin
        vid_elig    = vid_req & ~vid_gnt_q;
        dma_elig    = dma_req & ~dma_gnt_q;
        cpu_elig    = cpu_req & ~cpu_gnt_q;
        cpu_promote = cpu_elig & (cpu_wait_q == WAIT_MAX);
        winner      = REQ_NONE;
        if (cpu_promote) begin
            winner = REQ_CPU;
        end else if (vid_elig) begin
            winner = REQ_VID;
        end else if (dma_elig) begin
            winner = REQ_DMA;
        end else if (cpu_elig) begin
            winner = REQ_CPU;
        end
    end

    // Grant pulse and RAM strobe/address/data for the winner; address and data hold when idle
    always_comb begin
        vid_gnt_d  = (winner == REQ_VID);
        dma_gnt_d  = (winner == REQ_DMA);
        cpu_gnt_d  = (winner == REQ_CPU);
        ram_wr_d   = (winner == REQ_CPU) & cpu_we;
        ram_rd_d   = (winner != REQ_NONE) & ~ram_wr_d;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (winner)
            REQ_VID: ram_addr_d = vid_addr;
            REQ_DMA: ram_addr_d = dma_addr;
            REQ_CPU: ram_addr_d = cpu_addr;
            default: ;
        endcase
        if (ram_wr_d) begin
            ram_din_d = cpu_wdata;
        end
        // Writes produce no return, so they travel the tag pipe as empty slots
        issue_tag = ram_rd_d ? winner : REQ_NONE;
    end

    // Read return: capture RAM data and steer rvalid by the tag that arrives with it
    always_comb begin
        rdata_d      = (ret_tag != REQ_NONE) ? ram_q : rdata_q;
        vid_rvalid_d = (ret_tag == REQ_VID);
        dma_rvalid_d = (ret_tag == REQ_DMA);
        cpu_rvalid_d = (ret_tag == REQ_CPU);
    end

    // CPU wait counter: counts losing cycles, saturates, clears on grant or when the CPU gives up
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (!cpu_req || cpu_gnt_q || (winner == REQ_CPU)) begin
            cpu_wait_d = '0;
        end else if (cpu_wait_q != WAIT_MAX) begin
            cpu_wait_d = cpu_wait_q + WAIT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vid_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            rdata_q      <= '0;
            vid_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_wait_q   <= '0;
        end else begin
            vid_gnt_q    <= vid_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            ram_rd_q     <= ram_rd_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            rdata_q      <= rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_wait_q   <= cpu_wait_d;
        end
    end

    gx4000_tag_pipe #(
        .DEPTH (RAM_LAT + 1)
    ) u_tag_pipe (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    assign vid_gnt     = vid_gnt_q;
    assign dma_gnt     = dma_gnt_q;
    assign cpu_gnt     = cpu_gnt_q;
    assign ram_rd      = ram_rd_q;
    assign ram_wr      = ram_wr_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign rdata       = rdata_q;
    assign vid_rvalid  = vid_rvalid_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_starved = (cpu_wait_q == WAIT_MAX);

endmodule

// File: tb/tb_gx4000_asic_ram_arb.sv
// Bench for the ASIC RAM arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: requesters drop req one cycle after seeing their gnt, as registered requesters would.
module tb_gx4000_asic_ram_arb;
    import gx4000_pkg::*;

    localparam int AW         = ASIC_RAM_AW;
    localparam int RAM_LAT    = 3;
    localparam int STARVE_MAX = 15;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          vid_req, dma_req, cpu_req, cpu_we;
    logic [AW-1:0] vid_addr, dma_addr, cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          vid_gnt, dma_gnt, cpu_gnt;
    logic [7:0]    rdata;
    logic          vid_rvalid, dma_rvalid, cpu_rvalid;
    logic [AW-1:0] ram_addr;
    logic          ram_rd, ram_wr;
    logic [7:0]    ram_din, ram_q;
    logic          cpu_starved;

    gx4000_asic_ram_arb #(
        .ADDR_W     (AW),
        .RAM_LAT    (RAM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_gnt     (vid_gnt),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_gnt     (dma_gnt),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .rdata       (rdata),
        .vid_rvalid  (vid_rvalid),
        .dma_rvalid  (dma_rvalid),
        .cpu_rvalid  (cpu_rvalid),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_din     (ram_din),
        .ram_q       (ram_q),
        .cpu_starved (cpu_starved)
    );

    always #5 clk_sys = ~clk_sys;

    // Power-on RAM contents, shared by the RAM model and the reference model
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        if (a == 14'h0100) return 8'hA5;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    // ---------------- RAM model: synchronous, RAM_LAT cycles read latency ----------------
    logic [7:0] ram_mem [16384];
    bit         ram_wrt [16384];
    logic [7:0] q_pipe  [RAM_LAT];

    function automatic logic [7:0] ram_byte(input logic [AW-1:0] a);
        return ram_wrt[a] ? ram_mem[a] : init_byte(a);
    endfunction

    // RAM array and read-data delay line
    always @(posedge clk_sys) begin
        if (ram_wr) begin
            ram_mem[ram_addr] <= ram_din;
            ram_wrt[ram_addr] <= 1'b1;
        end
        q_pipe[0] <= ram_rd ? ram_byte(ram_addr) : 8'hEE;
        for (int i = 1; i < RAM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RAM_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        int         who;
        logic [7:0] dat;
    } ret_t;

    ret_t          retq[$];
    logic [7:0]    shadow    [16384];
    bit            shadow_wr [16384];
    int            cyc = 0;
    bit            m_vid_gnt, m_dma_gnt, m_cpu_gnt, m_rd, m_wr;
    bit            m_vid_rv, m_dma_rv, m_cpu_rv;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din, m_rdata;
    int            m_wait;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] mem_now(input logic [AW-1:0] a);
        return shadow_wr[a] ? shadow[a] : init_byte(a);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic model_edge();
        bit   v_ok, d_ok, c_ok;
        int   win;
        ret_t r;
        if (!reset_n) begin
            {m_vid_gnt, m_dma_gnt, m_cpu_gnt, m_rd, m_wr} = '0;
            {m_vid_rv, m_dma_rv, m_cpu_rv} = '0;
            m_addr  = '0;
            m_din   = '0;
            m_rdata = '0;
            m_wait  = 0;
            retq.delete();
        end else begin
            {m_vid_rv, m_dma_rv, m_cpu_rv} = '0;
            if (retq.size() != 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                case (r.who)
                    1:       m_vid_rv = 1'b1;
                    2:       m_dma_rv = 1'b1;
                    default: m_cpu_rv = 1'b1;
                endcase
                m_rdata = r.dat;
            end
            v_ok = vid_req && !m_vid_gnt;
            d_ok = dma_req && !m_dma_gnt;
            c_ok = cpu_req && !m_cpu_gnt;
            if (c_ok && m_wait == STARVE_MAX) win = 3;
            else if (v_ok)                    win = 1;
            else if (d_ok)                    win = 2;
            else if (c_ok)                    win = 3;
            else                              win = 0;
            if (!cpu_req || m_cpu_gnt || win == 3) m_wait = 0;
            else if (m_wait < STARVE_MAX)          m_wait++;
            m_vid_gnt = (win == 1);
            m_dma_gnt = (win == 2);
            m_cpu_gnt = (win == 3);
            m_wr      = (win == 3) && cpu_we;
            m_rd      = (win != 0) && !m_wr;
            if (win == 1) m_addr = vid_addr;
            if (win == 2) m_addr = dma_addr;
            if (win == 3) m_addr = cpu_addr;
            if (m_wr) begin
                m_din             = cpu_wdata;
                shadow[m_addr]    = cpu_wdata;
                shadow_wr[m_addr] = 1'b1;
            end
            if (m_rd) begin
                r.due = cyc + RAM_LAT + 1;
                r.who = win;
                r.dat = mem_now(m_addr);
                retq.push_back(r);
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_eq("gnt", 64'({vid_gnt, dma_gnt, cpu_gnt}), 64'({m_vid_gnt, m_dma_gnt, m_cpu_gnt}));
        check_eq("strobe", 64'({ram_rd, ram_wr}), 64'({m_rd, m_wr}));
        check_eq("ram_addr", 64'(ram_addr), 64'(m_addr));
        check_eq("ram_din", 64'(ram_din), 64'(m_din));
        check_eq("rvalid", 64'({vid_rvalid, dma_rvalid, cpu_rvalid}), 64'({m_vid_rv, m_dma_rv, m_cpu_rv}));
        check_eq("rdata", 64'(rdata), 64'(m_rdata));
        check_eq("starved", 64'(cpu_starved), 64'(m_wait == STARVE_MAX));
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later
    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        compare_all();
    endtask

    // ---------------- requester agents ----------------
    bit v_hit, d_hit, c_hit;

    // Drop a request one cycle after its gnt was seen
    task automatic react();
        if (v_hit) vid_req = 1'b0;
        if (d_hit) dma_req = 1'b0;
        if (c_hit) cpu_req = 1'b0;
        v_hit = vid_gnt;
        d_hit = dma_gnt;
        c_hit = cpu_gnt;
    endtask

    task automatic clear_hits();
        {v_hit, d_hit, c_hit} = '0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 14'h0100;
            1:       return 14'h2000;
            2:       return 14'h3FFF;
            default: return 14'($urandom_range(0, 16383));
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            react();
        end
    endtask

    task automatic rand_stim();
        react();
        if (!vid_req && $urandom_range(0, 99) < 45) begin
            vid_req  = 1'b1;
            vid_addr = pick_addr();
        end
        if (!dma_req && $urandom_range(0, 99) < 35) begin
            dma_req  = 1'b1;
            dma_addr = pick_addr();
        end
        if (!cpu_req && $urandom_range(0, 99) < 30) begin
            cpu_req   = 1'b1;
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = pick_addr();
            cpu_wdata = 8'($urandom);
        end
    endtask

    // Lone video read of 0x0100 from an idle arbiter
    task automatic single_vid_read(input string tag);
        int k;
        bit seen;
        vid_req  = 1'b1;
        vid_addr = 14'h0100;
        k        = 0;
        seen     = 1'b0;
        while (!seen && k < 20) begin
            step();
            k++;
            if (k == 1)
                check_eq({tag, "_first_gnt"},
                         64'({vid_gnt, dma_gnt, cpu_gnt, ram_rd, ram_wr, ram_addr}),
                         64'({5'b10010, 14'h0100}));
            if (vid_rvalid) begin
                seen = 1'b1;
                check_eq({tag, "_rdata"}, 64'(rdata), 64'(8'hA5));
            end
            react();
        end
        check_eq({tag, "_latency"}, 64'(k), 64'(RAM_LAT + 2));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int       k, ng, nr, nrv, nrd;
        logic [5:0] order;

        reset_n   = 1'b0;
        vid_req   = 1'b0;
        dma_req   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        vid_addr  = '0;
        dma_addr  = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        clear_hits();

        // 1: reset state, then a single video read
        step();
        step();
        check_eq("reset_ctrl",
                 64'({vid_gnt, dma_gnt, cpu_gnt, vid_rvalid, dma_rvalid, cpu_rvalid, ram_rd, ram_wr, cpu_starved}),
                 64'(0));
        check_eq("reset_data", 64'({ram_addr, ram_din, rdata}), 64'(0));
        reset_n = 1'b1;
        step();
        single_vid_read("t1");
        idle(4);

        // 2: all three requesters at once
        vid_req  = 1'b1; vid_addr = 14'h0100;
        dma_req  = 1'b1; dma_addr = pick_addr();
        cpu_req  = 1'b1; cpu_we   = 1'b0; cpu_addr = 14'h2000;
        order    = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vid_gnt) order = {order[3:0], 2'd1};
            if (dma_gnt) order = {order[3:0], 2'd2};
            if (cpu_gnt) order = {order[3:0], 2'd3};
            react();
        end
        check_eq("t2_grant_order", 64'(order), 64'({2'd1, 2'd2, 2'd3}));
        idle(2);

        // 3: video and DMA hog the RAM while a CPU write waits
        clear_hits();
        vid_req  = 1'b1; vid_addr = pick_addr();
        dma_req  = 1'b1; dma_addr = pick_addr();
        cpu_req  = 1'b1; cpu_we   = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'h5A;
        k = 0;
        while (!cpu_starved && k < 40) begin
            step();
            k++;
            if (vid_gnt) vid_addr = pick_addr();
            if (dma_gnt) dma_addr = pick_addr();
        end
        check_eq("t3_wait_cycles", 64'(k), 64'(STARVE_MAX));
        step();
        check_eq("t3_cpu_win", 64'({cpu_gnt, ram_wr, ram_rd, vid_gnt, dma_gnt, cpu_starved}), 64'(6'b110000));
        check_eq("t3_write", 64'({ram_addr, ram_din}), 64'({14'h3FFF, 8'h5A}));
        cpu_req = 1'b0;
        vid_req = 1'b0;
        dma_req = 1'b0;
        step();
        check_eq("t3_wait_cleared", 64'(cpu_starved), 64'(0));
        clear_hits();
        idle(RAM_LAT + 4);

        // 4: back-to-back alternating video and DMA reads
        clear_hits();
        vid_req = 1'b1; vid_addr = pick_addr();
        dma_req = 1'b1; dma_addr = 14'h3FFF;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            ng += int'(vid_gnt) + int'(dma_gnt) + int'(cpu_gnt);
            nr += int'(vid_rvalid) + int'(dma_rvalid) + int'(cpu_rvalid);
            if (vid_gnt) vid_addr = pick_addr();
            if (dma_gnt) dma_addr = pick_addr();
        end
        vid_req = 1'b0;
        dma_req = 1'b0;
        for (int i = 0; i < RAM_LAT + 4; i++) begin
            step();
            ng += int'(vid_gnt) + int'(dma_gnt) + int'(cpu_gnt);
            nr += int'(vid_rvalid) + int'(dma_rvalid) + int'(cpu_rvalid);
        end
        check_eq("t4_grants", 64'(ng), 64'(20));
        check_eq("t4_returns", 64'(nr), 64'(20));
        clear_hits();

        // 5: reset lands while a CPU read is in flight
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
        step();
        check_eq("t5_cpu_gnt", 64'(cpu_gnt), 64'(1));
        step();
        cpu_req = 1'b0;
        reset_n = 1'b0;
        nrv = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nrv += int'(cpu_rvalid);
        end
        reset_n = 1'b1;
        clear_hits();
        for (int i = 0; i < RAM_LAT + 4; i++) begin
            step();
            nrv += int'(cpu_rvalid);
        end
        check_eq("t5_no_cpu_rvalid", 64'(nrv), 64'(0));
        single_vid_read("t5");
        idle(4);

        // 6: one held CPU read issues exactly once
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
        nrd = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            nrd += int'(ram_rd);
            react();
        end
        check_eq("t6_single_issue", 64'(nrd), 64'(1));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            rand_stim();
        end
        vid_req = 1'b0;
        dma_req = 1'b0;
        cpu_req = 1'b0;
        idle(RAM_LAT + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
